// File: rtl/serial_add_ctrl_pkg.sv
// Shared constants and FSM encoding for the bit-serial adder/subtractor.
package serial_add_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the only arithmetic in the serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial A+B+c_in / A-B with valid/ready handshake; one bit per RUN cycle, LSB first.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;

    full_adder u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c_in  (carry),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            carry     <= 1'b0;
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            sum       <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + 1, so only the operand and carry seed differ.
                        a_sr  <= a;
                        b_sr  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : c_in;
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {fa_sum, res_sr[WIDTH-1:1]};
                    carry  <= fa_cout;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        // Publish the result only once complete; carry still holds the MSB carry-in here.
                        sum       <= {fa_sum, res_sr[WIDTH-1:1]};
                        c_out     <= fa_cout;
                        ovf       <= carry ^ fa_cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed corner cases plus random traffic against an arithmetic model.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid = 1'b0, c_in = 1'b0, sub = 1'b0, out_ready = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       in_ready, out_valid, c_out, ovf, busy;
    logic [7:0] sum;

    logic        iv32 = 1'b0, ci32 = 1'b0, sb32 = 1'b0, or32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        ir32, ov32, co32, of32, busy32;
    logic [31:0] sum32;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf), .busy(busy)
    );

    serial_add_ctrl #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
        .a(a32), .b(b32), .c_in(ci32), .sub(sb32), .out_valid(ov32),
        .out_ready(or32), .sum(sum32), .c_out(co32), .ovf(of32), .busy(busy32)
    );

    int cmp_cnt = 0;
    int err_cnt = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected {ovf, c_out, sum} from plain integer arithmetic on 8-bit operands.
    function automatic logic [9:0] exp_res(input logic [7:0] ta, input logic [7:0] tb,
                                           input logic tci, input logic tsb);
        logic [7:0] bb;
        logic [8:0] full;
        logic       v;
        bb   = tsb ? ~tb : tb;
        full = {1'b0, ta} + {1'b0, bb} + {8'd0, (tsb ? 1'b1 : tci)};
        v    = (ta[7] == bb[7]) && (full[7] != ta[7]);
        return {v, full[8], full[7:0]};
    endfunction

    // Model: an accepted op becomes visible 8 edges later and is held until consumed.
    int         m_left = 0;
    logic       m_valid = 1'b0;
    logic [7:0] m_sum = '0;
    logic       m_c = 1'b0, m_o = 1'b0;
    logic [9:0] m_pend = '0;
    int         ops_done = 0;
    logic       m_idle;
    assign m_idle = !m_valid && (m_left == 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left  <= 0;
            m_valid <= 1'b0;
            m_sum   <= '0;
            m_c     <= 1'b0;
            m_o     <= 1'b0;
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid  <= 1'b0;
                ops_done <= ops_done + 1;
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_valid              <= 1'b1;
                {m_o, m_c, m_sum}    <= m_pend;
            end
        end else if (in_valid) begin
            m_pend <= exp_res(a, b, c_in, sub);
            m_left <= 8;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_in_ready", in_ready, m_idle);
            check("cyc_out_valid", out_valid, m_valid);
            check("cyc_busy", busy, !m_idle);
            check("cyc_sum", sum, m_sum);
            check("cyc_c_out", c_out, m_c);
            check("cyc_ovf", ovf, m_o);
        end
    end

    // Issue one op on the 8-bit DUT; leaves it in DONE with out_ready low.
    task automatic op8(input string nm, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tci, input logic tsb, input logic [9:0] exp, input int exp_lat);
        int n;
        @(posedge clk); #1;
        check({nm, "_in_ready"}, in_ready, 1);
        a = ta; b = tb; c_in = tci; sub = tsb; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_latency"}, n, exp_lat);
        check({nm, "_result"}, {ovf, c_out, sum}, exp);
        check({nm, "_model"}, exp_res(ta, tb, tci, tsb), exp);
    endtask

    task automatic consume8();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        int seen;
        int start;
        int cyc;

        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_flags", {c_out, ovf}, 0);
        check("rst32_out", {ov32, busy32, co32, of32, sum32}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h00}, 9);
        consume8();
        op8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h80}, 9);
        consume8();
        op8("add_7f_00_ci", 8'h7F, 8'h00, 1'b1, 1'b0, {1'b1, 1'b0, 8'h80}, 9);
        consume8();

        // Backpressure: result must hold and new requests must be ignored.
        op8("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, {1'b0, 1'b0, 8'hFE}, 9);
        for (int i = 0; i < 5; i++) begin
            a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
            @(posedge clk); #1;
            check("bp_hold", {out_valid, in_ready, ovf, c_out, sum}, {1'b1, 1'b0, 1'b0, 1'b0, 8'hFE});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("bp_release", {in_ready, out_valid, busy, sum}, {1'b1, 1'b0, 1'b0, 8'hFE});

        // Reset while the fourth bit is being processed.
        a = 8'h33; b = 8'h44; sub = 1'b0; c_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrun_rst_outs", {out_valid, busy, ovf, c_out, sum}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("midrun_rst_ready", in_ready, 1);
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("midrun_no_valid", seen, 0);

        // 32-bit carry ripple through every bit.
        a32 = 32'hFFFF_FFFF; b32 = '0; ci32 = 1'b1; sb32 = 1'b0; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        n = 1;
        while (!ov32 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("w32_latency", n, 33);
        check("w32_result", {of32, co32, sum32}, {1'b0, 1'b1, 32'h0});
        or32 = 1'b1;
        @(posedge clk); #1;
        or32 = 1'b0;
        check("w32_idle", {ir32, ov32}, 2'b10);

        // Random traffic with random backpressure.
        start = ops_done;
        cyc = 0;
        while ((ops_done - start) < 1000 && cyc < 40000) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = 8'($urandom);
            b         = 8'($urandom);
            c_in      = 1'($urandom);
            sub       = 1'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            cyc++;
        end
        check("random_ops_done", ((ops_done - start) >= 1000), 1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
